// File: rtl/vending_disp_decoder.sv
// vending_disp_decoder
// Watches the vending machine's two 7-segment digits and its done flag.
// It turns the display back into a binary credit value and ignores glitches.
// A record is queued for each settled change.
// It also counts completed vends.
module vending_disp_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done_in,
  input  logic [6:0] lsb7seg_in,
  input  logic [6:0] msb7seg_in,
  output logic       rec_valid,
  input  logic       rec_ready,
  output logic [6:0] rec_value,
  output logic       rec_done,
  output logic       rec_err,
  output logic [6:0] credit_out,
  output logic [7:0] vend_count,
  output logic       overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 1;
  localparam logic [3:0] CNT_MAX    = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACCEPT = (STABLE_CYCLES > 1) ? 4'(STABLE_CYCLES - 2) : 4'd0;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // Returns {err, digit}; blank is a legal "0", anything unknown flags err
  function automatic logic [4:0] decode_digit(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h10;
    case (pat)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
      7'h00:   res = 5'h00;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  logic [14:0]      raw_sample;
  logic [14:0]      sample_q;
  logic [3:0]       stable_cnt;
  logic             same_sample;
  logic             accept;

  logic [4:0]       lsb_dec;
  logic [4:0]       msb_dec;
  logic [6:0]       new_value;
  logic             new_err;
  logic             new_done;

  logic             acc_done;
  logic [6:0]       acc_value;
  logic             acc_err;
  logic             push;

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic             fifo_full;
  logic             pop;
  logic             write_en;
  logic [8:0]       head;

  assign raw_sample  = {done_in, msb7seg_in, lsb7seg_in};
  assign same_sample = (raw_sample == sample_q);
  assign accept      = (STABLE_CYCLES == 1) ? 1'b1 : (same_sample && (stable_cnt == CNT_ACCEPT));

  assign lsb_dec   = decode_digit(lsb7seg_in);
  assign msb_dec   = decode_digit(msb7seg_in);
  assign new_value = 7'(msb_dec[3:0]) * 7'd10 + 7'(lsb_dec[3:0]);
  assign new_err   = lsb_dec[4] | msb_dec[4];
  assign new_done  = done_in;

  assign push = accept && ({new_done, new_value, new_err} != {acc_done, acc_value, acc_err});

  assign rec_valid = (occupancy != '0);
  assign fifo_full = (occupancy == OCC_FULL);
  assign pop       = rec_valid & rec_ready;
  assign write_en  = push && (!fifo_full || pop);
  assign head      = mem[rd_ptr];

  assign rec_done   = rec_valid ? head[8]   : 1'b0;
  assign rec_value  = rec_valid ? head[7:1] : 7'd0;
  assign rec_err    = rec_valid ? head[0]   : 1'b0;
  assign credit_out = acc_value;

  // Sample register and run-length counter that decide when the display has settled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_q   <= '0;
      stable_cnt <= '0;
    end else begin
      sample_q <= raw_sample;
      if (!same_sample) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 4'd1;
      end
    end
  end

  // Accepted display state, updated even when its record is dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_done   <= 1'b0;
      acc_value  <= '0;
      acc_err    <= 1'b0;
      vend_count <= '0;
    end else if (push) begin
      acc_done  <= new_done;
      acc_value <= new_value;
      acc_err   <= new_err;
      if (new_done && !acc_done) begin
        vend_count <= vend_count + 8'd1;
      end
    end
  end

  // Record storage; entries are only observed through the valid-gated head
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[wr_ptr] <= {new_done, new_value, new_err};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({write_en, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vending_disp_decoder.sv
// Testbench for vending_disp_decoder.
// A reference model queues the expected records at each clock edge.
// A monitor on the falling edge compares the DUT against that queue.
module tb_vending_disp_decoder;

  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic       done;
    logic [6:0] value;
    logic       err;
  } rec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       done_in = 1'b0;
  logic [6:0] lsb7seg_in = 7'h00;
  logic [6:0] msb7seg_in = 7'h00;
  logic       rec_ready = 1'b0;
  logic       rec_valid;
  logic [6:0] rec_value;
  logic       rec_done;
  logic       rec_err;
  logic [6:0] credit_out;
  logic [7:0] vend_count;
  logic       overflow;

  rec_t        expQ[$];
  rec_t        modelA = '0;
  logic [14:0] lastSample = '0;
  int          runLen = 1;
  logic [7:0]  modelVend = '0;
  logic        modelOvf = 1'b0;
  int          checks = 0;
  int          errors = 0;
  byte unsigned digitPat[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  vending_disp_decoder #(
    .STABLE_CYCLES(STABLE),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .done_in(done_in),
    .lsb7seg_in(lsb7seg_in),
    .msb7seg_in(msb7seg_in),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_value(rec_value),
    .rec_done(rec_done),
    .rec_err(rec_err),
    .credit_out(credit_out),
    .vend_count(vend_count),
    .overflow(overflow)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic decodeModel(input logic [6:0] pat, output int digit, output bit bad);
    digit = 0;
    bad   = (pat != 7'h00);
    for (int i = 0; i < 10; i++) begin
      if (7'(digitPat[i]) == pat) begin
        digit = i;
        bad   = 1'b0;
      end
    end
  endtask

  // Reference model: a display state counts as settled once it has been seen
  // for STABLE consecutive edges; new settled tuples are queued unless full
  task automatic modelStep();
    logic [14:0] cur;
    int          md, ld;
    bit          mb, lb;
    rec_t        t;
    if (!reset) begin
      expQ.delete();
      modelA     = '0;
      lastSample = '0;
      runLen     = 1;
      modelVend  = '0;
      modelOvf   = 1'b0;
      return;
    end
    cur = {done_in, msb7seg_in, lsb7seg_in};
    if (cur == lastSample) runLen++;
    else runLen = 1;
    lastSample = cur;
    if (runLen == STABLE || STABLE == 1) begin
      decodeModel(msb7seg_in, md, mb);
      decodeModel(lsb7seg_in, ld, lb);
      t.done  = done_in;
      t.value = 7'(md * 10 + ld);
      t.err   = mb | lb;
      if (t != modelA) begin
        if (t.done && !modelA.done) modelVend++;
        modelA = t;
        if (expQ.size() < DEPTH) expQ.push_back(t);
        else modelOvf = 1'b1;
      end
    end
  endtask

  task automatic monitorStep();
    checkOutput("credit_out", int'(credit_out), int'(modelA.value));
    checkOutput("vend_count", int'(vend_count), int'(modelVend));
    checkOutput("overflow", int'(overflow), int'(modelOvf));
    checkOutput("rec_valid", int'(rec_valid), int'(expQ.size() != 0));
    if (expQ.size() == 0) begin
      checkOutput("empty_fields", int'({rec_done, rec_value, rec_err}), 0);
    end else begin
      checkOutput("rec_value", int'(rec_value), int'(expQ[0].value));
      checkOutput("rec_done", int'(rec_done), int'(expQ[0].done));
      checkOutput("rec_err", int'(rec_err), int'(expQ[0].err));
      if (rec_valid && rec_ready) void'(expQ.pop_front());
    end
  endtask

  // Model advances on every rising edge and on asynchronous reset
  initial forever begin
    @(posedge clock or negedge reset);
    modelStep();
  end

  // Monitor compares on the falling edge, away from the active edge
  initial forever begin
    @(negedge clock);
    if (reset) monitorStep();
  end

  task automatic applyStimulus(input logic d, input logic [6:0] m, input logic [6:0] l,
                               input logic rdy, input int cycles);
    done_in    = d;
    msb7seg_in = m;
    lsb7seg_in = l;
    rec_ready  = rdy;
    repeat (cycles) @(posedge clock);
    #2;
  endtask

  function automatic logic [6:0] randomPattern();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return 7'(digitPat[$urandom_range(0, 9)]);
    else if (r < 18) return 7'h00;
    else return 7'($urandom_range(0, 127));
  endfunction

  initial begin
    logic [7:0] startVend;

    // Reset with "00" on the display
    reset      = 1'b0;
    msb7seg_in = 7'h3F;
    lsb7seg_in = 7'h3F;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 7'h3F, 7'h3F, 1'b0, 20);
    checkOutput("reset_rec_valid", int'(rec_valid), 0);
    checkOutput("reset_credit", int'(credit_out), 0);
    checkOutput("reset_vend", int'(vend_count), 0);

    // Credit 15: valid must appear exactly STABLE edges after sampling
    applyStimulus(1'b0, 7'h06, 7'h6D, 1'b0, STABLE - 1);
    checkOutput("latency_early_valid", int'(rec_valid), 0);
    applyStimulus(1'b0, 7'h06, 7'h6D, 1'b0, 1);
    checkOutput("latency_valid", int'(rec_valid), 1);
    checkOutput("latency_value", int'(rec_value), 15);
    checkOutput("latency_credit", int'(credit_out), 15);
    applyStimulus(1'b0, 7'h06, 7'h6D, 1'b1, 3);

    // Short glitch on the units digit must be ignored
    applyStimulus(1'b0, 7'h06, 7'h4F, 1'b1, 3);
    applyStimulus(1'b0, 7'h06, 7'h6D, 1'b1, 10);
    checkOutput("glitch_credit", int'(credit_out), 15);
    checkOutput("glitch_no_record", int'(rec_valid), 0);

    // 256 vends at credit 25 wrap the counter back to its start
    startVend = modelVend;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 7'h5B, 7'h6D, 1'b1, STABLE + 1);
      applyStimulus(1'b1, 7'h5B, 7'h6D, 1'b1, STABLE + 1);
      if (i == 0) checkOutput("vend_once", int'(vend_count), int'(startVend + 8'd1));
    end
    checkOutput("vend_wrap", int'(vend_count), int'(startVend));

    // Invalid tens pattern decodes to 0 with err
    applyStimulus(1'b0, 7'h01, 7'h06, 1'b1, STABLE + 2);
    checkOutput("invalid_credit", int'(credit_out), 1);

    // Fill past capacity with the consumer stalled
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 7'h06, 7'(digitPat[i]), 1'b0, STABLE + 1);
    end
    checkOutput("overflow_set", int'(overflow), 1);
    checkOutput("full_valid", int'(rec_valid), 1);
    checkOutput("full_head", int'(rec_value), 10);

    // New record accepted on the same edge as a pop from the full FIFO
    applyStimulus(1'b0, 7'h07, 7'h07, 1'b0, STABLE - 1);
    applyStimulus(1'b0, 7'h07, 7'h07, 1'b1, 1);
    applyStimulus(1'b0, 7'h07, 7'h07, 1'b0, 2);
    checkOutput("pushpop_head", int'(rec_value), 11);
    applyStimulus(1'b0, 7'h07, 7'h07, 1'b1, DEPTH + 2);
    checkOutput("overflow_sticky", int'(overflow), 1);

    // Randomised display traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), randomPattern(), randomPattern(),
                    1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end

    // Asynchronous reset in the middle of traffic
    applyStimulus(1'b1, 7'h07, 7'h3F, 1'b0, STABLE + 1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_valid", int'(rec_valid), 0);
    checkOutput("midreset_credit", int'(credit_out), 0);
    checkOutput("midreset_vend", int'(vend_count), 0);
    checkOutput("midreset_overflow", int'(overflow), 0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 7'h3F, 7'h3F, 1'b1, 20);
    checkOutput("post_reset_valid", int'(rec_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_disp_decoder.md
# vending_disp_decoder

- Receive-side companion for the vending machine's display outputs: consumes `done_out`, `lsb7seg_out` and `msb7seg_out` and decodes the two 7-segment digits back to a binary credit value (0–99).
- Filters glitches with a stability window and emits one record per settled display change through a small FIFO with a valid/ready handshake.
- Also counts completed vends.
- Sits beside the vending machine core in the same clock domain and feeds status logic and bench checkers.

## Interface

Parameters:

- STABLE_CYCLES, 4: consecutive identical samples required before a display state is accepted; legal range 1–15.
- DEPTH, 4: record FIFO depth; power of two, 2–16.

Ports:

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; asserted at 0, released synchronously by the integrator.
- done_in  in  1  vending machine `done_out`.
- lsb7seg_in  in  7  units digit; bit0=a … bit6=g, 1 = segment lit.
- msb7seg_in  in  7  tens digit; same encoding.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts head record on a clock edge where rec_valid=1.
- rec_value  out  7  decoded credit, msb*10+lsb.
- rec_done  out  1  accepted done level.
- rec_err  out  1  at least one digit pattern invalid.
- credit_out  out  7  current accepted credit value.
- vend_count  out  8  number of accepted done rising edges; wraps 255→0.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.

## Operation

- **Segment decode.** Legal patterns:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 0x00 (blank) decodes to 0 and is not an error.
  - Any other pattern decodes to 0 and sets err for that sample.
- **Input stage.** `{done_in, msb7seg_in, lsb7seg_in}` is registered every edge into sample register S.
- **Stability counter.**
  - The counter CNT clears to 0 when the new sample differs from S, otherwise increments, saturating at STABLE_CYCLES.
  - The sample is accepted on the edge where CNT would reach STABLE_CYCLES−1 with S unchanged. For STABLE_CYCLES=1, every sample is accepted immediately.
- **Accepted state A.** A = {done, value, err}, reset to {0,0,0}. On acceptance:
  - If the decoded tuple differs from A, A is updated and a record equal to the new A is pushed.
  - An identical tuple (e.g. raw patterns differ but decode the same, such as 0x00 vs 0x3F) pushes nothing.
- **vend_count.** Increments when A.done goes 0→1. It is independent of FIFO state and still increments when the record is dropped.
- **credit_out.** Equals A.value.
- **FIFO.**
  - Circular, DEPTH entries, separate read/write pointers plus occupancy count.
  - A pop occurs on an edge with rec_valid & rec_ready. rec_value/rec_done/rec_err reflect the head entry and are 0 when empty.
  - Push while full without a simultaneous pop: the record is dropped, overflow is set, and A is still updated.
  - Push and pop on the same edge while full: both occur, occupancy unchanged.
  - Push while empty: no bypass; rec_valid rises the following cycle.
- **rec_ready while rec_valid=0.** Ignored.
- **Reset mid-operation.** Asserting reset asynchronously clears S, CNT, A, FIFO pointers/count, vend_count and overflow. Any in-flight record is lost.

## Timing

- **Reset values.**
  - rec_valid=0, rec_value=0, rec_done=0, rec_err=0, credit_out=0, vend_count=0, overflow=0.
  - S=0, CNT=0.
- **Latency.** For a new display state first present at the inputs before edge E0 and held, with an empty FIFO:
  - Sampled at E0; accepted at edge E0+STABLE_CYCLES−1 (A, credit_out, vend_count update there).
  - FIFO write on the same edge; rec_valid=1 after edge E0+STABLE_CYCLES−1.
  - Total: STABLE_CYCLES edges from the sampling edge.
- **Glitch rejection.** A change lasting fewer than STABLE_CYCLES samples never updates A.
- **Throughput.** One record per cycle into and out of the FIFO; no combinational path from rec_ready to rec_valid.

## Test plan

- **Reset state.** Reset low, inputs 0x3F/0x3F/done=0, then release → after 20 cycles rec_valid=0, credit_out=0, vend_count=0 (the "00" display decodes equal to the reset state).
- **Credit update.** Display msb=0x06, lsb=0x6D held → exactly STABLE_CYCLES edges after sampling, rec_valid=1, rec_value=15, rec_done=0, rec_err=0, credit_out=15.
- **Glitch rejection.** With STABLE_CYCLES=4, apply lsb=0x4F for 3 cycles, then revert → no record, credit_out unchanged.
- **Vend event.** Display 25 held, then done_in=1 held → one record {25,1,0}, vend_count increments by 1. Repeating the sequence 256 times wraps vend_count to 0.
- **Invalid pattern.** msb=0x01, lsb=0x06 held → record {value=1, done=0, err=1}.
- **Overflow and full-FIFO push/pop.**
  - With rec_ready=0, push DEPTH+1 distinct values → the first DEPTH are retained in order, the last is dropped, overflow=1 and stays 1 until reset.
  - Full FIFO, rec_ready=1 on the same edge as a new push → occupancy stays DEPTH and the new record appears last.
